// File: rtl/tetris_pkg.sv
// Shared board geometry, cell type and read-FSM state encoding for the Tetris row server.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int CELL_W  = 16;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_COMMIT
    } rd_state_t;

endpackage

// File: rtl/board_ram.sv
// Simple dual-port board storage: one synchronous read port, one write port.
// A same-address read and write in one cycle returns the previous contents.
module board_ram #(
    parameter int DEPTH  = 200,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/board_row_server.sv
// Serves whole board rows to the display through a shadow buffer committed atomically,
// and owns the game-logic write path plus the board clear sweeper.
module board_row_server
    import tetris_pkg::*;
#(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H,
    parameter int CELL_W  = tetris_pkg::CELL_W
) (
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           LD_Row,
    input  logic [7:0]                     rowNum,
    output logic [BOARD_W-1:0][CELL_W-1:0] Row,
    output logic                           rowReady,
    input  logic                           wr_en,
    input  logic [4:0]                     wr_row,
    input  logic [3:0]                     wr_col,
    input  logic [CELL_W-1:0]              wr_data,
    input  logic                           clear_board,
    output logic                           clear_busy
);

    localparam int CELLS  = BOARD_W * BOARD_H;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int COL_W  = $clog2(BOARD_W + 2);

    rd_state_t state_q, state_d;

    logic                           ld_prev_q, ld_prev_d;
    logic                           req;
    logic [7:0]                     row_q, row_d;
    logic [COL_W-1:0]               col_q, col_d;
    logic                           pend_q, pend_d;
    logic [7:0]                     pend_row_q, pend_row_d;
    logic                           cap_vld_q, cap_vld_d;
    logic [COL_W-1:0]               cap_col_q, cap_col_d;
    logic [BOARD_W-1:0][CELL_W-1:0] shadow_q, shadow_d;
    logic [BOARD_W-1:0][CELL_W-1:0] row_buf_q, row_buf_d;
    logic                           ready_q, ready_d;
    logic                           clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]              clr_addr_q, clr_addr_d;

    logic                           start;
    logic [7:0]                     start_row;

    logic                           ram_we;
    logic [ADDR_W-1:0]              ram_waddr;
    logic [CELL_W-1:0]              ram_wdata;
    logic [ADDR_W-1:0]              ram_raddr;
    logic [CELL_W-1:0]              ram_rdata;

    assign req       = LD_Row & ~ld_prev_q;
    assign ld_prev_d = LD_Row;
    assign ram_raddr = ADDR_W'(int'(row_q) * BOARD_W + int'(col_q));

    // Read FSM. col_q doubles as the stall counter in COMMIT so that in-range and
    // out-of-range rows both commit on the 12th edge after the request.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        pend_d     = pend_q;
        pend_row_d = pend_row_q;
        cap_vld_d  = 1'b0;
        cap_col_d  = cap_col_q;
        shadow_d   = shadow_q;
        row_buf_d  = row_buf_q;
        ready_d    = ready_q;
        start      = 1'b0;
        start_row  = req ? rowNum : pend_row_q;

        if (cap_vld_q) begin
            shadow_d[cap_col_q] = ram_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (req || pend_q) begin
                    start  = 1'b1;
                    pend_d = 1'b0;
                end
            end
            ST_FETCH: begin
                cap_vld_d = 1'b1;
                cap_col_d = col_q;
                if (int'(col_q) == BOARD_W - 1) begin
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_COMMIT;
                col_d   = COL_W'(BOARD_W + 1);
            end
            ST_COMMIT: begin
                if (int'(col_q) >= BOARD_W + 1) begin
                    row_buf_d = shadow_q;
                    if (req || pend_q) begin
                        // Chain straight into the queued row; Row is already stale again.
                        start  = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (req && !start && state_q != ST_IDLE) begin
            pend_d     = 1'b1;
            pend_row_d = rowNum;
        end

        if (start) begin
            row_d   = start_row;
            col_d   = '0;
            ready_d = 1'b0;
            if (int'(start_row) >= BOARD_H) begin
                state_d  = ST_COMMIT;
                shadow_d = '0;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    // Clear sweeper owns the write port while busy; game writes are dropped meanwhile.
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        ram_we     = 1'b0;
        ram_waddr  = clr_addr_q;
        ram_wdata  = '0;

        if (clr_busy_q) begin
            ram_we = 1'b1;
            if (int'(clr_addr_q) == CELLS - 1) begin
                clr_busy_d = 1'b0;
                clr_addr_d = '0;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end else begin
            if (clear_board) begin
                clr_busy_d = 1'b1;
                clr_addr_d = '0;
            end
            if (wr_en && int'(wr_row) < BOARD_H && int'(wr_col) < BOARD_W) begin
                ram_we    = 1'b1;
                ram_waddr = ADDR_W'(int'(wr_row) * BOARD_W + int'(wr_col));
                ram_wdata = wr_data;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ld_prev_q  <= 1'b0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            row_buf_q  <= '0;
            cap_vld_q  <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_prev_q  <= ld_prev_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            row_buf_q  <= row_buf_d;
            cap_vld_q  <= cap_vld_d;
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_ff @(posedge Clk) begin
        row_q      <= row_d;
        col_q      <= col_d;
        pend_row_q <= pend_row_d;
        cap_col_q  <= cap_col_d;
        shadow_q   <= shadow_d;
    end

    board_ram #(
        .DEPTH  (CELLS),
        .WIDTH  (CELL_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign Row        = row_buf_q;
    assign rowReady   = ready_q;
    assign clear_busy = clr_busy_q;

endmodule

// File: tb/tb_board_row_server.sv
// Directed bench for board_row_server: table-driven row requests plus hand-written
// sequences for pending requests, read/write collision, clear and mid-fetch reset.
module tb_board_row_server;

    typedef logic [9:0][15:0] row_t;

    typedef struct {
        logic [4:0]  r;
        logic [3:0]  c;
        logic [15:0] d;
    } wvec_t;

    typedef struct {
        logic [7:0] row;
        int         hold;
        row_t       exp;
    } rvec_t;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        LD_Row = 1'b0;
    logic [7:0]  rowNum = '0;
    row_t        Row;
    logic        rowReady;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_row = '0;
    logic [3:0]  wr_col = '0;
    logic [15:0] wr_data = '0;
    logic        clear_board = 1'b0;
    logic        clear_busy;

    int total = 0;
    int bad = 0;

    board_row_server dut (
        .Clk         (Clk),
        .reset       (reset),
        .LD_Row      (LD_Row),
        .rowNum      (rowNum),
        .Row         (Row),
        .rowReady    (rowReady),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .clear_board (clear_board),
        .clear_busy  (clear_busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_cell(input logic [4:0] r, input logic [3:0] c, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_row  = r;
        wr_col  = c;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Issues a request with LD_Row held for 'hold' cycles; returns edges until rowReady.
    task automatic do_request(input logic [7:0] r, input int hold, output int lat);
        LD_Row = 1'b1;
        rowNum = r;
        tick();
        lat = 0;
        check("ready_drop", 160'(rowReady), 160'(0));
        while (!rowReady && lat < 40) begin
            if (lat == hold - 1) LD_Row = 1'b0;
            tick();
            lat++;
        end
        LD_Row = 1'b0;
    endtask

    task automatic run_clear(input int mid_req_at, input logic [7:0] mid_row, input row_t mid_exp);
        int   n;
        logic seen_mid;
        seen_mid = 1'b0;
        clear_board = 1'b1;
        tick();
        clear_board = 1'b0;
        check("clear_busy_rise", 160'(clear_busy), 160'(1));
        n = 0;
        while (clear_busy && n < 400) begin
            LD_Row = (mid_req_at >= 0 && n == mid_req_at);
            rowNum = mid_row;
            clear_board = (n == 50);
            if (n == 150) begin
                wr_en = 1'b1; wr_row = 5'd0; wr_col = 4'd0; wr_data = 16'h0FFF;
            end else begin
                wr_en = 1'b0;
            end
            if (mid_req_at >= 0 && n == mid_req_at + 20) begin
                check("clear_mid_ready", 160'(rowReady), 160'(1));
                check("clear_mid_row", Row, mid_exp);
                seen_mid = 1'b1;
            end
            tick();
            n++;
        end
        LD_Row = 1'b0; clear_board = 1'b0; wr_en = 1'b0;
        check("clear_busy_len", 160'(n), 160'(200));
        if (mid_req_at >= 0) check("clear_mid_seen", 160'(seen_mid), 160'(1));
    endtask

    wvec_t wv[9];
    rvec_t rv[7];

    initial begin
        int   lat;
        int   changes;
        int   t1, t2;
        row_t v1, v2, prev, snap, e;
        logic stay_ok;

        // Reset state
        tick(); tick();
        check("rst_row", Row, '0);
        check("rst_ready", 160'(rowReady), 160'(0));
        check("rst_busy", 160'(clear_busy), 160'(0));
        reset = 1'b0;
        tick();

        run_clear(-1, 8'd0, '0);

        wv[0] = '{5'd3,  4'd4,  16'h0F00};
        wv[1] = '{5'd19, 4'd9,  16'hABCD};
        wv[2] = '{5'd19, 4'd0,  16'h1234};
        wv[3] = '{5'd20, 4'd0,  16'hFFFF};
        wv[4] = '{5'd5,  4'd10, 16'hEEEE};
        wv[5] = '{5'd1,  4'd0,  16'h0111};
        wv[6] = '{5'd2,  4'd0,  16'h0222};
        wv[7] = '{5'd5,  4'd0,  16'h0555};
        wv[8] = '{5'd7,  4'd0,  16'h0AAA};
        foreach (wv[i]) write_cell(wv[i].r, wv[i].c, wv[i].d);

        e = '0; e[4] = 16'h0F00;            rv[0] = '{8'd3,   5, e};
        e = '0;                             rv[1] = '{8'd25,  1, e};
        e = '0; e[9] = 16'hABCD; e[0] = 16'h1234; rv[2] = '{8'd19, 2, e};
        e = '0;                             rv[3] = '{8'd20,  1, e};
        e = '0; e[0] = 16'h0555;            rv[4] = '{8'd5,   1, e};
        e = '0;                             rv[5] = '{8'd6,   3, e};
        e = '0;                             rv[6] = '{8'd255, 1, e};

        foreach (rv[i]) begin
            do_request(rv[i].row, rv[i].hold, lat);
            check($sformatf("lat_row%0d", rv[i].row), 160'(lat), 160'(12));
            check($sformatf("data_row%0d", rv[i].row), Row, rv[i].exp);
            snap = Row;
            stay_ok = 1'b1;
            for (int k = 0; k < 15; k++) begin
                tick();
                if (!rowReady || Row !== snap) stay_ok = 1'b0;
            end
            check($sformatf("single_fetch_row%0d", rv[i].row), 160'(stay_ok), 160'(1));
        end

        // Row 1 then rows 2 and 5 during the fetch: only 1 and 5 are committed.
        prev = Row;
        changes = 0; t1 = -1; t2 = -1; v1 = '0; v2 = '0;
        LD_Row = 1'b1; rowNum = 8'd1;
        tick();
        LD_Row = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin LD_Row = 1'b1; rowNum = 8'd2; end
            else if (c == 5) begin LD_Row = 1'b1; rowNum = 8'd5; end
            else LD_Row = 1'b0;
            tick();
            if (Row !== prev) begin
                changes++;
                if (changes == 1) begin t1 = c; v1 = Row; end
                if (changes == 2) begin t2 = c; v2 = Row; end
                prev = Row;
            end
        end
        check("pend_changes", 160'(changes), 160'(2));
        check("pend_t1", 160'(t1), 160'(12));
        check("pend_v1", 160'(v1[0]), 160'(16'h0111));
        check("pend_t2", 160'(t2), 160'(24));
        check("pend_v2", 160'(v2[0]), 160'(16'h0555));
        check("pend_ready", 160'(rowReady), 160'(1));

        // Write (7,0) in the cycle the read address for (7,0) is presented.
        LD_Row = 1'b1; rowNum = 8'd7;
        tick();
        LD_Row = 1'b0;
        wr_en = 1'b1; wr_row = 5'd7; wr_col = 4'd0; wr_data = 16'h0BBB;
        tick();
        wr_en = 1'b0;
        lat = 1;
        while (!rowReady && lat < 40) begin tick(); lat++; end
        check("coll_lat", 160'(lat), 160'(12));
        e = '0; e[0] = 16'h0AAA;
        check("coll_old", Row, e);
        do_request(8'd7, 1, lat);
        e = '0; e[0] = 16'h0BBB;
        check("coll_new", Row, e);

        // Reset 5 cycles into a fetch.
        LD_Row = 1'b1; rowNum = 8'd1;
        tick();
        LD_Row = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        #1;
        check("midrst_row", Row, '0);
        check("midrst_ready", 160'(rowReady), 160'(0));
        tick();
        reset = 1'b0;
        stay_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rowReady || Row !== '0) stay_ok = 1'b0;
        end
        check("midrst_no_commit", 160'(stay_ok), 160'(1));

        // Clear over nonzero cells; row 19 requested mid-clear still sees its data.
        e = '0; e[9] = 16'hABCD; e[0] = 16'h1234;
        run_clear(10, 8'd19, e);
        do_request(8'd0, 1, lat);
        check("post_clear_row0", Row, '0);
        do_request(8'd19, 1, lat);
        check("post_clear_row19", Row, '0);
        do_request(8'd3, 1, lat);
        check("post_clear_row3", Row, '0);
        check("post_clear_lat", 160'(lat), 160'(12));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_row_server.md
BOARD_ROW_SERVER -- requirements
Module: board_row_server

Interface
REQ-001 Parameter BOARD_W, default 10, meaning cells per board row.
REQ-002 Parameter BOARD_H, default 20, meaning rows per board.
REQ-003 Parameter CELL_W, default 16, meaning bits per cell, with the colour in [11:0] as R[11:8], G[7:4], B[3:0].
REQ-004 Clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  meaning the asynchronous, active-high reset.
REQ-006 LD_Row  input  1  meaning the display row-load request, which may be held high for several cycles.
REQ-007 rowNum  input  8  meaning the requested board row index, sampled with LD_Row.
REQ-008 Row  output  BOARD_W x CELL_W  meaning the committed row buffer, where element i is column i.
REQ-009 rowReady  output  1  meaning that Row holds the complete, most recently requested row.
REQ-010 wr_en  input  1  meaning a game-logic cell write strobe.
REQ-011 wr_row  input  5  meaning the write row index.
REQ-012 wr_col  input  4  meaning the write column index.
REQ-013 wr_data  input  CELL_W  meaning the cell value to write.
REQ-014 clear_board  input  1  meaning a one-cycle request to zero the entire board.
REQ-015 clear_busy  output  1  meaning a board clear is in progress.

Function
REQ-016 The board SHALL be stored as BOARD_W*BOARD_H cells, row-major, at address row*BOARD_W+col, with one synchronous read port (1-cycle latency) and one write port.
REQ-017 A request SHALL be a rising edge of LD_Row (high now, low the previous cycle); holding LD_Row high SHALL NOT generate further requests.
REQ-018 The read FSM SHALL have the states IDLE, FETCH, DRAIN and COMMIT.
REQ-019 IDLE -> FETCH SHALL occur on a request or a pending request; the FSM latches rowNum, clears rowReady and sets col to 0.
REQ-020 FETCH SHALL issue one read address per cycle for col 0..BOARD_W-1 and move to DRAIN after col BOARD_W-1.
REQ-021 Returned data SHALL be captured into a shadow buffer one cycle after each address.
REQ-022 DRAIN SHALL capture the last cell and then go to COMMIT.
REQ-023 COMMIT SHALL copy the shadow buffer to Row in a single cycle, set rowReady, and return to IDLE.
REQ-024 Row SHALL never change except in COMMIT or on reset, so that no partially fetched row is ever visible.
REQ-025 Latency SHALL be fixed: rowReady is low from the first edge after the request and high from the edge 12 cycles after the request edge (BOARD_W=10).
REQ-026 rowNum >= BOARD_H SHALL skip FETCH and DRAIN, load the shadow buffer with all zeros, and commit with the same 12-cycle latency by stalling.
REQ-027 A request arriving while the FSM is not IDLE SHALL be held in a one-deep pending register that overwrites any older pending request; it is served directly after COMMIT without passing through an IDLE wait cycle.
REQ-028 Writes SHALL take effect at the rising edge after wr_en is sampled high.
REQ-029 A same-cycle read and write to the same address SHALL return the old data.
REQ-030 wr_row >= BOARD_H or wr_col >= BOARD_W SHALL be ignored.
REQ-031 clear_board SHALL start a sweep writing zero to addresses 0..BOARD_W*BOARD_H-1, one address per cycle, with clear_busy high for exactly BOARD_W*BOARD_H cycles.
REQ-032 During a clear, wr_en SHALL be ignored, row requests SHALL still be served, and the read FSM is unaffected.
REQ-033 clear_board asserted while clear_busy is high SHALL be ignored.

Reset
REQ-034 Asserting reset SHALL immediately force the following state: read FSM = IDLE, Row = all zero, rowReady = 0, pending = 0, clear_busy = 0, sweep counter = 0 and LD_Row edge history = 0.
REQ-035 Board memory contents SHALL NOT be reset; software issues clear_board after reset.
REQ-036 Reset asserted mid-fetch or mid-clear SHALL abandon the operation without committing a partial Row.

Structure
REQ-037 BOARD_W, BOARD_H, CELL_W, the cell_t typedef (logic [CELL_W-1:0]) and the read-FSM state enum SHALL reside in the shared package tetris_pkg.
REQ-038 Storage SHALL be a sub-module, board_ram, with a simple dual-port synchronous read (old-data on collision), inferable as block RAM.
REQ-039 Request edge detection, the pending register, the read FSM, the shadow and committed buffers and the clear sweeper SHALL reside in board_row_server.

Verification
REQ-040 The bench SHALL cover: reset, clear_board, write cell(3,4)=16'h0F00, then request rowNum=3 with LD_Row held 5 cycles -> exactly one fetch; rowReady high 12 cycles after the edge; Row[4]=16'h0F00 and all other elements 0.
REQ-041 The bench SHALL cover: request rowNum=25 -> Row all zero and rowReady high after 12 cycles.
REQ-042 The bench SHALL cover: request row 1, then request rows 2 and 5 during the fetch -> row 1 is committed, then row 5 only, committed 12 cycles after row 1's commit; row 2 is never committed.
REQ-043 The bench SHALL cover: a write to (7,0) issued in the same cycle the read address for (7,0) is presented -> the commit shows the old value, and the next request shows the new value.
REQ-044 The bench SHALL cover: clear_board while board cells are nonzero -> clear_busy is high for 200 cycles, a wr_en during the clear is dropped, and subsequent requests return all zeros.
REQ-045 The bench SHALL cover: reset asserted 5 cycles into a fetch -> Row=0 and rowReady=0 immediately, with no commit after reset deasserts.
